// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared UART types and constants (TX state encoding, default baud)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_tx_state_t;

  // 100 MHz system clock / 115200 baud
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
//------------------------------------------------------------------------------
// uart_baud_gen : bit-period counter 0..CLKS_PER_BIT-1, bit_done on the last count
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  output logic bit_done
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping on bit_done means the owner only needs clear when entering timed states.
  always_ff @(posedge Clk) begin
    if (Reset || clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// uart_tx : FIFO-fed UART transmitter, 8N1-style framing, optional even parity
//           enabled by defining UART_TX_PARITY_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_t        state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  bit_done;
  logic                  baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                  parity;
`endif

  // Counter is held at zero until the first timed state so START begins on count 0.
  assign baud_clear = (state == IDLE) || (state == FETCH);
  assign shreg_next = shreg >> 1;

  // The strobe is combinational so the FIFO's registered data is valid in FETCH;
  // gating with Reset keeps the FIFO from popping a byte the FSM would never take.
  assign fifo_rd_en = (state == IDLE) && !fifo_empty && !Reset;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          shreg   <= fifo_data_in;
          bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
          parity  <= ^fifo_data_in;
`endif
          tx      <= 1'b0;
          state   <= START;
        end

        START: begin
          if (bit_done) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              tx       <= parity;
              state    <= PARITY;
`else
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg_next;
              tx      <= shreg_next[0];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            if ((STOP_BITS == 1) || stop_idx) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx (1 and 2 stop-bit instances)
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_empty;
  logic          sel;
  logic          fe1, fe2;
  logic          rd1, tx1, busy1;
  logic          rd2, tx2, busy2;
  logic          rd_s, tx_s, busy_s;

  always #5 Clk = ~Clk;

  // Only the selected instance sees a non-empty FIFO; the other stays idle.
  assign fe1    = sel ? 1'b1 : fifo_empty;
  assign fe2    = sel ? fifo_empty : 1'b1;
  assign rd_s   = sel ? rd2 : rd1;
  assign tx_s   = sel ? tx2 : tx1;
  assign busy_s = sel ? busy2 : busy1;

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .fifo_data_in(fifo_data_in), .fifo_empty(fe1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .fifo_data_in(fifo_data_in), .fifo_empty(fe2),
    .fifo_rd_en(rd2), .tx(tx2), .busy(busy2)
  );

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] fq[$];   // FIFO contents
  bit            fb[$];   // expected serial bits of every frame, in line order

  typedef struct {
    logic [7:0] data;
    logic       stop2;
    logic [0:8] lead;     // start bit then data bits, in line order
    logic       par;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference framing: start 0, data LSB first, optional even parity, stop ones.
  task automatic model_frame(input logic [DW-1:0] d, input int nstop);
    fb.push_back(1'b0);
    for (int i = 0; i < DW; i++) fb.push_back(d[i]);
    if (P == 1) fb.push_back(^d);
    for (int i = 0; i < nstop; i++) fb.push_back(1'b1);
  endtask

  task automatic table_frame(input vec_t v);
    for (int j = 0; j < 9; j++) fb.push_back(v.lead[j]);
    if (P == 1) fb.push_back(v.par);
    fb.push_back(1'b1);
    if (v.stop2) fb.push_back(1'b1);
  endtask

  // Streams bytes through the selected instance and checks every cycle against
  // the timeline: IDLE (strobe), FETCH, frame bits of CPB cycles each, repeat.
  task automatic run_seq(input logic [DW-1:0] bytes[$], input int late, input string tag);
    int nb, fl, per, total, k, f, bi;
    logic e_tx, e_busy, e_rd;
    bit pend;
    nb    = bytes.size();
    fl    = 1 + DW + P + (sel ? 2 : 1);
    per   = 2 + fl * CPB;
    total = nb * per + 3;
    pend  = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge Clk);
      if (pend) begin
        fifo_data_in = fq.pop_front();
        pend = 0;
      end
      if (c == 0) fq.push_back(bytes[0]);
      if (c == late) for (int i = 1; i < nb; i++) fq.push_back(bytes[i]);
      fifo_empty = (fq.size() == 0);
      #1;
      f = c / per;
      k = c % per;
      if (f >= nb) begin
        e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0;
      end else if (k == 0) begin
        e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b1;
      end else if (k == 1) begin
        e_tx = 1'b1; e_busy = 1'b1; e_rd = 1'b0;
      end else begin
        bi = f * fl + (k - 2) / CPB;
        e_tx = fb[bi]; e_busy = 1'b1; e_rd = 1'b0;
      end
      chk($sformatf("%s c%0d tx", tag, c), {31'b0, tx_s}, {31'b0, e_tx});
      chk($sformatf("%s c%0d busy", tag, c), {31'b0, busy_s}, {31'b0, e_busy});
      chk($sformatf("%s c%0d rd_en", tag, c), {31'b0, rd_s}, {31'b0, e_rd});
      if (rd_s && (fq.size() > 0)) pend = 1;
    end
  endtask

  initial begin
    logic [DW-1:0] bq[$];
    int            nb, late;

    tbl[0] = '{8'hA5, 1'b0, 9'b010100101, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 9'b010000000, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 9'b000000000, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 9'b011111111, 1'b0};
    tbl[4] = '{8'h3C, 1'b1, 9'b000111100, 1'b0};

    // Reset state, with data waiting in the FIFO: no strobe while in reset
    Reset = 1'b1; fifo_empty = 1'b0; fifo_data_in = '0; sel = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("reset tx1", {31'b0, tx1}, 32'd1);
    chk("reset busy1", {31'b0, busy1}, 32'd0);
    chk("reset rd1", {31'b0, rd1}, 32'd0);
    chk("reset tx2", {31'b0, tx2}, 32'd1);
    chk("reset busy2", {31'b0, busy2}, 32'd0);
    fifo_empty = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;

    // Empty FIFO for 100 cycles
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      #1;
      chk($sformatf("empty c%0d rd1", c), {31'b0, rd1}, 32'd0);
      chk($sformatf("empty c%0d tx1", c), {31'b0, tx1}, 32'd1);
      chk($sformatf("empty c%0d busy1", c), {31'b0, busy1}, 32'd0);
    end

    // Directed single frames from the vector table
    for (int t = 0; t < 5; t++) begin
      sel = tbl[t].stop2;
      fb.delete();
      table_frame(tbl[t]);
      bq.delete();
      bq.push_back(tbl[t].data);
      run_seq(bq, 0, $sformatf("vec%0d", t));
    end

    // Back-to-back A5 then 01; second byte arrives mid-frame
    sel = 1'b0;
    fb.delete();
    table_frame(tbl[0]);
    table_frame(tbl[1]);
    bq.delete();
    bq.push_back(8'hA5);
    bq.push_back(8'h01);
    run_seq(bq, 3, "b2b");

    // Reset in the 3rd cycle of data bit 2 of 0xFF
    sel = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(negedge Clk);
      if (c == 1) fifo_data_in = fq.pop_front();
      if (c == 0) fq.push_back(8'hFF);
      fifo_empty = (fq.size() == 0);
      if (c == 16) Reset = 1'b1;
      #1;
      if (c == 0) chk("rst-seq strobe", {31'b0, rd1}, 32'd1);
      if (c == 16) chk("rst-seq bit2 tx", {31'b0, tx1}, 32'd1);
    end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("after-rst tx", {31'b0, tx1}, 32'd1);
    chk("after-rst busy", {31'b0, busy1}, 32'd0);
    chk("after-rst rd_en", {31'b0, rd1}, 32'd0);
    fb.delete();
    model_frame(8'h3C, 1);
    bq.delete();
    bq.push_back(8'h3C);
    run_seq(bq, 0, "post-rst");

    // Randomized streams against the framing model
    for (int r = 0; r < 6; r++) begin
      sel  = 1'($urandom_range(0, 1));
      nb   = $urandom_range(1, 3);
      late = $urandom_range(0, 5);
      fb.delete();
      bq.delete();
      for (int i = 0; i < nb; i++) begin
        bq.push_back(DW'($urandom));
        model_frame(bq[i], sel ? 2 : 1);
      end
      run_seq(bq, late, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
